// File: rtl/coin_input_cond.sv
// Coin/cancel input conditioner: per-lane sync + debounce + rise event, shared A/B arbiter.
// Optional post-pulse lockout is enabled with `define COIN_HOLDOFF_EN.

module coin_deb_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} st_t;

  logic s1_q, s2_q;
  st_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only advances while waiting; it never wraps because the wait resolves at CNT_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW: if (s2_q) begin
        state_d = RISE_WAIT;
        cnt_d   = '0;
      end
      RISE_WAIT: begin
        if (!s2_q)                state_d = LOW;
        else if (cnt_q == CNT_MAX) state_d = HIGH;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      HIGH: if (!s2_q) begin
        state_d = FALL_WAIT;
        cnt_d   = '0;
      end
      FALL_WAIT: begin
        if (s2_q)                 state_d = HIGH;
        else if (cnt_q == CNT_MAX) state_d = LOW;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = LOW;
    endcase
  end

  always_comb begin
    level_o = (state_q == HIGH) || (state_q == FALL_WAIT);
    rise_o  = (state_q == RISE_WAIT) && s2_q && (cnt_q == CNT_MAX);
  end
endmodule

module coin_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic A,
  output logic B,
  output logic a_level,
  output logic b_level,
  output logic holdoff
);
  localparam int NUM_LANES = 2;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_hold
      $error("HOLDOFF_CYCLES must be >= 1");
    end
  endgenerate

  logic [NUM_LANES-1:0] raw, lvl, rise;
  assign raw = {btn_b_raw, btn_a_raw};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      coin_deb_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw[g]),
        .level_o(lvl[g]),
        .rise_o (rise[g])
      );
    end
  endgenerate

  logic hold;
  logic ev_a, ev_b;
  logic a_q, b_q;

  // A wins a simultaneous qualify; the B event is dropped, not deferred.
  assign ev_a = rise[0] & ~hold;
  assign ev_b = rise[1] & ~rise[0] & ~hold;

`ifdef COIN_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  logic [HO_W-1:0] ho_q, ho_d;

  assign hold = (ho_q != '0);

  always_comb begin
    ho_d = ho_q;
    if (ev_a || ev_b) ho_d = HO_W'(HOLDOFF_CYCLES);
    else if (hold)    ho_d = ho_q - HO_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ho_q <= '0;
    else       ho_q <= ho_d;
  end
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= ev_a;
      b_q <= ev_b;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign a_level = lvl[0];
  assign b_level = lvl[1];
  assign holdoff = hold;
endmodule

// File: tb/tb_coin_input_cond.sv
// Bench for coin_input_cond (default build): directed cases plus random bouncing inputs
// checked against a run-length debounce model.

module tb_coin_input_cond;
  localparam int DEB = 16;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset, btn_a_raw, btn_b_raw;
  logic A, B, a_level, b_level, holdoff;

  coin_input_cond #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .A        (A),
    .B        (B),
    .a_level  (a_level),
    .b_level  (b_level),
    .holdoff  (holdoff)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a level flips once the synchronized input has disagreed with it
  // for DEB+1 consecutive samples; a flip to 1 is a rise event.
  bit hist_a[$], hist_b[$];
  bit m_lvl[2];
  int m_run[2];
  bit m_A, m_B;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist_a = '{1'b0, 1'b0};
    hist_b = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
    end
    m_A = 1'b0;
    m_B = 1'b0;
  endtask

  task automatic model_edge(input bit ra, input bit rb);
    bit s[2];
    bit rise[2];
    s[0] = hist_a.pop_front();
    s[1] = hist_b.pop_front();
    hist_a.push_back(ra);
    hist_b.push_back(rb);
    for (int i = 0; i < 2; i++) begin
      rise[i] = 1'b0;
      if (s[i] != m_lvl[i]) m_run[i]++;
      else                  m_run[i] = 0;
      if (m_run[i] == DEB + 1) begin
        m_lvl[i] = s[i];
        m_run[i] = 0;
        rise[i]  = s[i];
      end
    end
    m_A = rise[0];
    m_B = rise[1] && !rise[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_A"}, A, m_A);
    chk({tag, "_B"}, B, m_B);
    chk({tag, "_alvl"}, a_level, m_lvl[0]);
    chk({tag, "_blvl"}, b_level, m_lvl[1]);
    chk({tag, "_hold"}, holdoff, 1'b0);
  endtask

  task automatic step(input bit ra, input bit rb, input string tag);
    btn_a_raw = ra;
    btn_b_raw = rb;
    @(posedge clk);
    if (!reset) model_edge(ra, rb);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int n, input bit ra, input bit rb);
    btn_a_raw = ra;
    btn_b_raw = rb;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (n) step(ra, rb, "rst");
    reset = 1'b0;
  endtask

  int np;
  int seg_left[2];
  bit seg_val[2];

  initial begin
    reset = 1'b0;
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    model_reset();
    #2;

    // 1: reset with idle inputs
    do_reset(5, 1'b0, 1'b0);

    // 2: clean coin press, pulse on edge 19, release gives only a level drop
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, "t2");
      chk("t2_B_edge", B, k == 19);
      chk("t2_blvl_edge", b_level, k >= 19);
    end
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 1'b0, "t2r");
      chk("t2r_B", B, 1'b0);
      chk("t2r_blvl_edge", b_level, k < 19);
    end

    // 3: bouncing coin switch, then held
    np = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, ((k / 5) % 2) == 0, "t3b");
      np += B;
    end
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1, "t3h");
      np += B;
      chk("t3_B_edge", B, k == 19);
    end
    chk("t3_one_pulse", np == 1, 1'b1);
    repeat (25) step(1'b0, 1'b0, "t3idle");

    // 4: short glitch on cancel
    np = 0;
    for (int k = 0; k < 40; k++) begin
      step(k < 10, 1'b0, "t4");
      np += A;
      chk("t4_alvl", a_level, 1'b0);
    end
    chk("t4_no_pulse", np == 0, 1'b1);

    // 5: simultaneous rise, A wins, B dropped
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b1, "t5");
      np += B;
      chk("t5_A_edge", A, k == 19);
    end
    chk("t5_no_B", np == 0, 1'b1);
    chk("t5_blvl", b_level, 1'b1);
    repeat (25) step(1'b0, 1'b0, "t5idle");

    // 6: reset in the middle of a rise wait, then idle
    repeat (10) step(1'b1, 1'b0, "t6pre");
    do_reset(3, 1'b0, 1'b0);
    np = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0, "t6post");
      np += A + B;
    end
    chk("t6_no_pulse", np == 0, 1'b1);

    // Held through reset release counts as a fresh press
    do_reset(4, 1'b1, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      step(1'b1, 1'b0, "thr");
      chk("thr_A_edge", A, k == 19);
    end
    repeat (25) step(1'b0, 1'b0, "thridle");

    // Random bouncing segments on both lines
    for (int i = 0; i < 2; i++) begin
      seg_left[i] = 0;
      seg_val[i]  = 1'b0;
    end
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (seg_left[i] == 0) begin
          seg_val[i]  = $urandom_range(0, 1) != 0;
          seg_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40)
                                                    : $urandom_range(1, 20);
        end
        seg_left[i]--;
      end
      step(seg_val[0], seg_val[1], "rnd");
      chk("rnd_excl", A && B, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
